// File: rtl/awg_pkg.sv
// Shared definitions for the AWG waveform player: default widths and FSM encoding.
package awg_pkg;

    localparam int unsigned AWG_ID_WIDTH   = 11;
    localparam int unsigned AWG_ADDR_WIDTH = 16;
    localparam int unsigned AWG_DATA_WIDTH = 64;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        LATCH  = 3'd2,
        PLAY   = 3'd3,
        DRAIN  = 3'd4
    } awg_state_e;

endpackage

// File: rtl/awg_wave_player.sv
// AWG waveform player: looks up a waveform descriptor by id, streams the
// waveform words out of wave RAM and presents them as registered DAC words.
module awg_wave_player
    import awg_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = AWG_ID_WIDTH,
    parameter int unsigned ADDR_WIDTH = AWG_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = AWG_DATA_WIDTH
) (
    input  logic                  I_clk_250mhz,
    input  logic                  I_rst_n,
    input  logic [ID_WIDTH-1:0]   I_tx_id,
    input  logic                  I_tx_ena,
    output logic [ID_WIDTH-1:0]   O_desc_addr,
    input  logic [ADDR_WIDTH-1:0] I_desc_start,
    input  logic [ADDR_WIDTH-1:0] I_desc_len,
    output logic [ADDR_WIDTH-1:0] O_mem_rd_addr,
    output logic                  O_mem_rd_en,
    input  logic [DATA_WIDTH-1:0] I_mem_rd_data,
    output logic [DATA_WIDTH-1:0] O_dac_data,
    output logic                  O_dac_valid,
    output logic                  O_busy,
    output logic                  O_err_overrun,
    input  logic                  I_err_clr,
    output logic [2:0]            O_state
);

    localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1);

    awg_state_e            state;
    logic [ID_WIDTH-1:0]   desc_addr;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [ADDR_WIDTH-1:0] remain_cnt;
    logic                  rd_en;
    logic                  busy;
    logic                  drain_cnt;
    logic                  rd_en_d1;
    logic                  dac_valid;
    logic [DATA_WIDTH-1:0] dac_data;
    logic                  err_overrun;

    // Playback sequencer: descriptor lookup, word-by-word read issue, pipeline drain.
    always_ff @(posedge I_clk_250mhz or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state      <= IDLE;
            desc_addr  <= '0;
            addr_cnt   <= '0;
            remain_cnt <= '0;
            rd_en      <= 1'b0;
            busy       <= 1'b0;
            drain_cnt  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (I_tx_ena) begin
                        desc_addr <= I_tx_id;
                        busy      <= 1'b1;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    state <= LATCH;
                end
                LATCH: begin
                    addr_cnt   <= I_desc_start;
                    remain_cnt <= I_desc_len;
                    if (I_desc_len == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        rd_en <= 1'b1;
                        state <= PLAY;
                    end
                end
                PLAY: begin
                    // rd_en is registered, so it drops on the same edge that leaves PLAY
                    addr_cnt   <= addr_cnt + CNT_ONE;
                    remain_cnt <= remain_cnt - CNT_ONE;
                    if (remain_cnt == CNT_ONE) begin
                        rd_en     <= 1'b0;
                        drain_cnt <= 1'b0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: begin
                    rd_en <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Two-stage alignment of read enable with RAM data; DAC word forced to zero when idle.
    always_ff @(posedge I_clk_250mhz or negedge I_rst_n) begin
        if (!I_rst_n) begin
            rd_en_d1  <= 1'b0;
            dac_valid <= 1'b0;
            dac_data  <= '0;
        end else begin
            rd_en_d1  <= rd_en;
            dac_valid <= rd_en_d1;
            dac_data  <= rd_en_d1 ? I_mem_rd_data : '0;
        end
    end

    // Sticky overrun flag: a request outside IDLE sets it, and a set beats a clear.
    always_ff @(posedge I_clk_250mhz or negedge I_rst_n) begin
        if (!I_rst_n) begin
            err_overrun <= 1'b0;
        end else if (I_tx_ena && (state != IDLE)) begin
            err_overrun <= 1'b1;
        end else if (I_err_clr) begin
            err_overrun <= 1'b0;
        end
    end

    assign O_desc_addr   = desc_addr;
    assign O_mem_rd_addr = addr_cnt;
    assign O_mem_rd_en   = rd_en;
    assign O_dac_data    = dac_data;
    assign O_dac_valid   = dac_valid;
    assign O_busy        = busy;
    assign O_err_overrun = err_overrun;
    assign O_state       = state;

endmodule

// File: tb/tb_awg_wave_player.sv
// Scoreboard bench for awg_wave_player with behavioural descriptor and wave RAMs.
`timescale 1ns/100ps
module tb_awg_wave_player;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] I_tx_id = '0;
    logic        I_tx_ena = 1'b0;
    logic [10:0] O_desc_addr;
    logic [15:0] I_desc_start = '0;
    logic [15:0] I_desc_len = '0;
    logic [15:0] O_mem_rd_addr;
    logic        O_mem_rd_en;
    logic [63:0] I_mem_rd_data = '0;
    logic [63:0] O_dac_data;
    logic        O_dac_valid;
    logic        O_busy;
    logic        O_err_overrun;
    logic        I_err_clr = 1'b0;
    logic [2:0]  O_state;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int busy_lo = 0;
    int busy_hi = -1;
    bit rd_prev  = 1'b0;
    bit val_prev = 1'b0;

    logic [15:0] d_start [2048];
    logic [15:0] d_len   [2048];

    logic [63:0] rd_addr_q [$];
    logic [63:0] val_q     [$];
    int          rd_lat_q  [$];
    int          val_lat_q [$];

    awg_wave_player #(
        .ID_WIDTH   (11),
        .ADDR_WIDTH (16),
        .DATA_WIDTH (64)
    ) dut (
        .I_clk_250mhz  (clk),
        .I_rst_n       (rst_n),
        .I_tx_id       (I_tx_id),
        .I_tx_ena      (I_tx_ena),
        .O_desc_addr   (O_desc_addr),
        .I_desc_start  (I_desc_start),
        .I_desc_len    (I_desc_len),
        .O_mem_rd_addr (O_mem_rd_addr),
        .O_mem_rd_en   (O_mem_rd_en),
        .I_mem_rd_data (I_mem_rd_data),
        .O_dac_data    (O_dac_data),
        .O_dac_valid   (O_dac_valid),
        .O_busy        (O_busy),
        .O_err_overrun (O_err_overrun),
        .I_err_clr     (I_err_clr),
        .O_state       (O_state)
    );

    // 250 MHz clock
    always #2 clk = ~clk;

    // Cycle index, advanced on every rising edge
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] wave_word(input logic [15:0] a);
        return {a ^ 16'hA5A5, ~a, a, a + 16'h1234};
    endfunction

    // Descriptor RAM, one-cycle read latency
    always @(posedge clk) begin
        I_desc_start <= d_start[O_desc_addr];
        I_desc_len   <= d_len[O_desc_addr];
    end

    // Wave RAM, one-cycle read latency
    always @(posedge clk) begin
        if (O_mem_rd_en) I_mem_rd_data <= wave_word(O_mem_rd_addr);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [10:0] id, input bit accept);
        int unsigned len;
        logic [15:0] a;
        I_tx_id  = id;
        I_tx_ena = 1'b1;
        if (accept) begin
            len     = 32'(d_len[id]);
            busy_lo = cyc + 1;
            if (len == 0) begin
                busy_hi = cyc + 2;
            end else begin
                busy_hi = cyc + 4 + int'(len);
                rd_lat_q.push_back(cyc + 3);
                val_lat_q.push_back(cyc + 5);
                for (int unsigned i = 0; i < len; i++) begin
                    a = d_start[id] + 16'(i);
                    rd_addr_q.push_back(64'(a));
                    val_q.push_back(wave_word(a));
                end
            end
        end
        tick();
        I_tx_ena = 1'b0;
        I_tx_id  = '0;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while ((O_busy || val_q.size() != 0 || rd_addr_q.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        chk("idle_busy", O_busy, 1'b0);
        chk("idle_words_left", val_q.size(), 0);
        repeat (3) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_desc_addr"}, O_desc_addr, 0);
        chk({tag, "_rd_addr"}, O_mem_rd_addr, 0);
        chk({tag, "_rd_en"}, O_mem_rd_en, 0);
        chk({tag, "_dac_data"}, O_dac_data, 0);
        chk({tag, "_dac_valid"}, O_dac_valid, 0);
        chk({tag, "_busy"}, O_busy, 0);
        chk({tag, "_err"}, O_err_overrun, 0);
        chk({tag, "_state"}, O_state, 0);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (O_mem_rd_en) begin
                if (!rd_prev) begin
                    if (rd_lat_q.size() == 0) chk("rd_unexpected", O_mem_rd_en, 1'b0);
                    else chk("rd_first_cycle", cyc, rd_lat_q.pop_front());
                end
                if (rd_addr_q.size() == 0) chk("rd_extra", O_mem_rd_en, 1'b0);
                else chk("rd_addr", O_mem_rd_addr, rd_addr_q.pop_front());
            end
            if (O_dac_valid) begin
                if (!val_prev) begin
                    if (val_lat_q.size() == 0) chk("valid_unexpected", O_dac_valid, 1'b0);
                    else chk("valid_first_cycle", cyc, val_lat_q.pop_front());
                end
                if (val_q.size() == 0) chk("valid_extra", O_dac_valid, 1'b0);
                else chk("dac_data", O_dac_data, val_q.pop_front());
            end else begin
                chk("dac_idle_zero", O_dac_data, 0);
            end
            chk("busy", O_busy, (cyc >= busy_lo && cyc <= busy_hi));
            rd_prev  = O_mem_rd_en;
            val_prev = O_dac_valid;
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            d_start[i] = '0;
            d_len[i]   = '0;
        end
        d_start[5]  = 16'h0100; d_len[5]  = 16'd4;
        d_start[9]  = 16'hFFFE; d_len[9]  = 16'd4;
        d_start[12] = 16'h0010; d_len[12] = 16'd0;
        d_start[7]  = 16'h2000; d_len[7]  = 16'd8;
        d_start[3]  = 16'h4000; d_len[3]  = 16'd100;
        d_start[20] = 16'h0300; d_len[20] = 16'd3;
        d_start[21] = 16'hFFFF; d_len[21] = 16'd2;

        #3;
        chk_all_zero("reset");
        fork
            monitor();
        join_none
        tick();
        tick();
        rst_n = 1'b1;

        // basic playback
        request(11'd5, 1'b1);
        chk("desc_addr_cycle1", O_desc_addr, 11'd5);
        wait_idle();

        // address wrap
        request(11'd9, 1'b1);
        wait_idle();

        // zero length: back in IDLE by cycle 3
        request(11'd12, 1'b1);
        tick();
        tick();
        chk("zero_len_state", O_state, 3'd0);
        wait_idle();

        // overrun: second request in cycle 4 ignored
        request(11'd7, 1'b1);
        repeat (3) tick();
        request(11'd5, 1'b0);
        chk("overrun_set", O_err_overrun, 1'b1);
        wait_idle();
        chk("overrun_sticky", O_err_overrun, 1'b1);
        I_err_clr = 1'b1;
        tick();
        I_err_clr = 1'b0;
        chk("overrun_cleared", O_err_overrun, 1'b0);

        // set wins over a simultaneous clear
        request(11'd20, 1'b1);
        I_err_clr = 1'b1;
        request(11'd5, 1'b0);
        I_err_clr = 1'b0;
        chk("set_beats_clr", O_err_overrun, 1'b1);
        wait_idle();
        I_err_clr = 1'b1;
        tick();
        I_err_clr = 1'b0;
        chk("clr_after_set", O_err_overrun, 1'b0);

        // back-to-back: second request in first IDLE cycle after DRAIN
        request(11'd20, 1'b1);
        repeat (4 + 3) tick();
        chk("b2b_first_idle", O_state, 3'd0);
        request(11'd21, 1'b1);
        chk("b2b_no_overrun", O_err_overrun, 1'b0);
        wait_idle();

        // reset in cycle 20 of a long playback
        request(11'd3, 1'b1);
        repeat (19) tick();
        chk("midplay_rd_en", O_mem_rd_en, 1'b1);
        rst_n = 1'b0;
        #0.5;
        chk_all_zero("midplay_reset");
        rd_addr_q.delete();
        val_q.delete();
        rd_lat_q.delete();
        val_lat_q.delete();
        busy_lo = 0;
        busy_hi = -1;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("post_reset_state", O_state, 3'd0);

        // request presented on the release edge
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        request(11'd5, 1'b1);
        chk("release_accept_state", O_state, 3'd1);
        wait_idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
